// File: rtl/y86_isa_pkg.sv
`default_nettype none
// ============================================================================
// y86_isa_pkg : Y86-64 icodes, instruction lengths and encoder state encoding
// Rev 1.0
// ============================================================================
package y86_isa_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] RNONE    = 4'hF;

    localparam logic [3:0] LEN_1    = 4'd1;
    localparam logic [3:0] LEN_2    = 4'd2;
    localparam logic [3:0] LEN_9    = 4'd9;
    localparam logic [3:0] LEN_10   = 4'd10;

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_EMIT       = 2'd1,
        S_HALTED_ERR = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/y86_instr_len.sv
`default_nettype none
// ============================================================================
// y86_instr_len : icode -> instruction length and field-presence flags
// Rev 1.0
// ============================================================================
module y86_instr_len
    import y86_isa_pkg::*;
(
    input  logic [3:0] icode,
    output logic [3:0] len,
    output logic       valid,
    output logic       has_regs,
    output logic       has_valc
);

    always_comb begin
        len      = 4'd0;
        valid    = 1'b0;
        has_regs = 1'b0;
        has_valc = 1'b0;
        case (icode)
            I_HALT, I_NOP, I_RET: begin
                len   = LEN_1;
                valid = 1'b1;
            end
            I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: begin
                len      = LEN_2;
                valid    = 1'b1;
                has_regs = 1'b1;
            end
            I_JXX, I_CALL: begin
                len      = LEN_9;
                valid    = 1'b1;
                has_valc = 1'b1;
            end
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
                len      = LEN_10;
                valid    = 1'b1;
                has_regs = 1'b1;
                has_valc = 1'b1;
            end
            default: begin
                len   = 4'd0;
                valid = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/y86_instr_encoder.sv
`default_nettype none
// ============================================================================
// y86_instr_encoder : serialises decoded Y86-64 fields into byte-wide memory writes
// Rev 1.0
// ============================================================================
module y86_instr_encoder
    import y86_isa_pkg::*;
#(
    parameter int unsigned MEM_SIZE  = 1024,
    parameter logic [63:0] BASE_ADDR = 64'd0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_code,
    input  logic [3:0]  in_fun,
    input  logic [3:0]  ra,
    input  logic [3:0]  rb,
    input  logic [63:0] val_c,
    input  logic        addr_load,
    input  logic [63:0] addr_value,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic [63:0] val_p,
    output logic        done,
    output logic        in_error,
    output logic        bad_mem
);

    state_t      state;
    state_t      next_state;

    logic [3:0]  instr_code;
    logic [3:0]  instr_fun;
    logic [3:0]  instr_ra;
    logic [3:0]  instr_rb;
    logic [63:0] instr_val_c;
    logic [3:0]  instr_len;
    logic        instr_has_regs;
    logic        instr_has_valc;
    logic [3:0]  byte_idx;

    logic [3:0]  dec_len;
    logic        dec_valid;
    logic        dec_has_regs;
    logic        dec_has_valc;

    logic        take;
    logic        err_icode;
    logic        err_mem;
    logic        last_byte;
    logic [64:0] end_addr;
    logic [2:0]  valc_sel;

    y86_instr_len u_len (
        .icode    (in_code),
        .len      (dec_len),
        .valid    (dec_valid),
        .has_regs (dec_has_regs),
        .has_valc (dec_has_valc)
    );

    assign take      = (state == S_IDLE) && !addr_load && in_valid;
    // 65-bit so a pointer near 2^64 cannot wrap past the bound
    assign end_addr  = {1'b0, val_p} + {61'd0, dec_len} - 65'd1;
    assign last_byte = (byte_idx == instr_len - 4'd1);

    always_comb begin
        next_state = state;
        err_icode  = 1'b0;
        err_mem    = 1'b0;
        case (state)
            S_IDLE: begin
                if (take) begin
                    if (!dec_valid) begin
                        err_icode  = 1'b1;
                        next_state = S_HALTED_ERR;
                    end else if (end_addr > (65'(MEM_SIZE) - 65'd1)) begin
                        err_mem    = 1'b1;
                        next_state = S_HALTED_ERR;
                    end else begin
                        next_state = S_EMIT;
                    end
                end
            end
            S_EMIT: begin
                if (last_byte) begin
                    next_state = S_IDLE;
                end
            end
            S_HALTED_ERR: next_state = S_HALTED_ERR;
            default:      next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            val_p          <= BASE_ADDR;
            in_ready       <= 1'b1;
            in_error       <= 1'b0;
            bad_mem        <= 1'b0;
            instr_code     <= 4'd0;
            instr_fun      <= 4'd0;
            instr_ra       <= 4'd0;
            instr_rb       <= 4'd0;
            instr_val_c    <= 64'd0;
            instr_len      <= 4'd0;
            instr_has_regs <= 1'b0;
            instr_has_valc <= 1'b0;
            byte_idx       <= 4'd0;
        end else begin
            in_ready <= (next_state == S_IDLE);
            if ((state == S_IDLE) && addr_load) begin
                val_p <= addr_value;
            end
            if (take) begin
                instr_code     <= in_code;
                instr_fun      <= in_fun;
                instr_ra       <= ra;
                instr_rb       <= rb;
                instr_val_c    <= val_c;
                instr_len      <= dec_len;
                instr_has_regs <= dec_has_regs;
                instr_has_valc <= dec_has_valc;
                byte_idx       <= 4'd0;
            end
            if (err_icode) begin
                in_error <= 1'b1;
            end
            if (err_mem) begin
                bad_mem <= 1'b1;
            end
            if (state == S_EMIT) begin
                byte_idx <= byte_idx + 4'd1;
                if (last_byte) begin
                    val_p <= val_p + {60'd0, instr_len};
                end
            end
        end
    end

    // valC starts at byte 2 when a register byte is present, else at byte 1
    assign valc_sel = byte_idx[2:0] - (instr_has_regs ? 3'd2 : 3'd1);

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = 64'd0;
        mem_wdata = 8'd0;
        done      = 1'b0;
        if (state == S_EMIT) begin
            mem_we   = 1'b1;
            mem_addr = val_p + {60'd0, byte_idx};
            done     = last_byte;
            if (byte_idx == 4'd0) begin
                mem_wdata = {instr_code, instr_fun};
            end else if ((byte_idx == 4'd1) && instr_has_regs) begin
                mem_wdata = {instr_ra, instr_rb};
            end else if (instr_has_valc) begin
                mem_wdata = instr_val_c[{valc_sel, 3'b000} +: 8];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_y86_instr_encoder.sv
`default_nettype none
// ============================================================================
// tb_y86_instr_encoder : directed self-checking bench for y86_instr_encoder
// Rev 1.0
// ============================================================================
module tb_y86_instr_encoder;

    localparam int MEM_SIZE = 1024;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_code;
    logic [3:0]  in_fun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] val_c;
    logic        addr_load;
    logic [63:0] addr_value;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [63:0] val_p;
    logic        done;
    logic        in_error;
    logic        bad_mem;

    logic [7:0]  mem [0:MEM_SIZE-1];
    int          total = 0;
    int          bad = 0;
    int          writes = 0;
    int          dones = 0;

    y86_instr_encoder #(.MEM_SIZE(MEM_SIZE), .BASE_ADDR(64'd0)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_code    (in_code),
        .in_fun     (in_fun),
        .ra         (ra),
        .rb         (rb),
        .val_c      (val_c),
        .addr_load  (addr_load),
        .addr_value (addr_value),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .val_p      (val_p),
        .done       (done),
        .in_error   (in_error),
        .bad_mem    (bad_mem)
    );

    always #5 clock = ~clock;

    // Memory model: outputs are stable mid-cycle, so capture on the falling edge
    always @(negedge clock) begin
        if (mem_we) begin
            if (mem_addr < 64'(MEM_SIZE)) mem[mem_addr[9:0]] = mem_wdata;
            writes++;
        end
        if (done) dones++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic load_addr(input logic [63:0] a);
        addr_load  = 1'b1;
        addr_value = a;
        tick();
        addr_load  = 1'b0;
    endtask

    task automatic put(input logic [3:0] c, input logic [3:0] f, input logic [3:0] a,
                       input logic [3:0] b, input logic [63:0] v);
        int t;
        t = 0;
        while (!in_ready && t < 30) begin
            tick();
            t++;
        end
        check("ready_before_put", {63'd0, in_ready}, 64'd1);
        in_code  = c;
        in_fun   = f;
        ra       = a;
        rb       = b;
        val_c    = v;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Called in the cycle that carries byte 0; returns in the done cycle
    task automatic wait_done(input string tag, input int exp_len);
        int lat;
        lat = 1;
        while (!done && lat < 20) begin
            tick();
            lat++;
        end
        check(tag, 64'(lat), 64'(exp_len));
    endtask

    initial begin
        logic [7:0] exp1 [10];
        logic [7:0] exp2 [12];
        int w0;
        int d0;

        exp1 = '{8'h30, 8'hF3, 8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
        exp2 = '{8'h60, 8'h23, 8'h80, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                 8'h00, 8'h90};
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_code    = 4'd0;
        in_fun     = 4'd0;
        ra         = 4'd0;
        rb         = 4'd0;
        val_c      = 64'd0;
        addr_load  = 1'b0;
        addr_value = 64'd0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Reset state
        check("rst_in_ready",  {63'd0, in_ready},  64'd1);
        check("rst_mem_we",    {63'd0, mem_we},    64'd0);
        check("rst_mem_addr",  mem_addr,           64'd0);
        check("rst_mem_wdata", {56'd0, mem_wdata}, 64'd0);
        check("rst_done",      {63'd0, done},      64'd0);
        check("rst_in_error",  {63'd0, in_error},  64'd0);
        check("rst_bad_mem",   {63'd0, bad_mem},   64'd0);
        check("rst_val_p",     val_p,              64'd0);

        // 1: irmovq at 0
        put(4'h3, 4'h0, 4'hF, 4'h3, 64'h0123456789ABCDEF);
        check("t1_first_addr", mem_addr, 64'd0);
        wait_done("t1_latency", 10);
        tick();
        check("t1_val_p", val_p, 64'd10);
        for (int i = 0; i < 10; i++) check($sformatf("t1_mem%0d", i), {56'd0, mem[i]}, {56'd0, exp1[i]});

        // 2: back-to-back addq, call, ret
        d0 = dones;
        put(4'h6, 4'h0, 4'h2, 4'h3, 64'hDEAD);
        wait_done("t2_addq_lat", 2);
        put(4'h8, 4'h0, 4'hF, 4'hF, 64'h40);
        wait_done("t2_call_lat", 9);
        put(4'h9, 4'h0, 4'h7, 4'h7, 64'hBEEF);
        wait_done("t2_ret_lat", 1);
        tick();
        check("t2_val_p", val_p, 64'd22);
        check("t2_dones", 64'(dones - d0), 64'd3);
        for (int i = 0; i < 12; i++) check($sformatf("t2_mem%0d", 10 + i), {56'd0, mem[10 + i]}, {56'd0, exp2[i]});

        // 3: invalid icode
        do_reset();
        load_addr(64'd5);
        check("t3_val_p_load", val_p, 64'd5);
        w0 = writes;
        put(4'hC, 4'h0, 4'h1, 4'h2, 64'd0);
        repeat (5) tick();
        check("t3_in_error", {63'd0, in_error}, 64'd1);
        check("t3_bad_mem",  {63'd0, bad_mem},  64'd0);
        check("t3_in_ready", {63'd0, in_ready}, 64'd0);
        check("t3_writes",   64'(writes - w0),  64'd0);
        check("t3_val_p",    val_p,             64'd5);
        do_reset();
        check("t3_err_clr",  {63'd0, in_error}, 64'd0);
        check("t3_val_p_rst", val_p,            64'd0);

        // 4: boundary
        load_addr(64'd1010);
        put(4'h3, 4'h0, 4'hF, 4'h3, 64'h1122334455667788);
        wait_done("t4_latency", 10);
        tick();
        check("t4_val_p",  val_p, 64'd1020);
        check("t4_m1010", {56'd0, mem[1010]}, 64'h30);
        check("t4_m1011", {56'd0, mem[1011]}, 64'hF3);
        check("t4_m1012", {56'd0, mem[1012]}, 64'h88);
        check("t4_m1019", {56'd0, mem[1019]}, 64'h11);
        w0 = writes;
        put(4'h5, 4'h0, 4'h1, 4'h2, 64'h8);
        repeat (4) tick();
        check("t4_bad_mem",  {63'd0, bad_mem},  64'd1);
        check("t4_in_error", {63'd0, in_error}, 64'd0);
        check("t4_in_ready", {63'd0, in_ready}, 64'd0);
        check("t4_writes",   64'(writes - w0),  64'd0);
        do_reset();
        load_addr(64'd1023);
        put(4'h1, 4'h0, 4'h0, 4'h0, 64'd0);
        wait_done("t4_nop_lat", 1);
        tick();
        check("t4_m1023",    {56'd0, mem[1023]}, 64'h10);
        check("t4_bad_fit",  {63'd0, bad_mem},   64'd0);
        check("t4_val_p_end", val_p,             64'd1024);

        // 5: addr_load wins over in_valid
        do_reset();
        addr_load  = 1'b1;
        addr_value = 64'd100;
        in_code    = 4'h1;
        in_fun     = 4'h0;
        in_valid   = 1'b1;
        tick();
        addr_load  = 1'b0;
        check("t5_val_p",    val_p,             64'd100);
        check("t5_no_write", {63'd0, mem_we},   64'd0);
        check("t5_ready",    {63'd0, in_ready}, 64'd1);
        tick();
        in_valid = 1'b0;
        wait_done("t5_lat", 1);
        check("t5_m100", {56'd0, mem[100]}, 64'h10);
        tick();
        check("t5_val_p_next", val_p, 64'd101);

        // 6: reset during byte 4 of irmovq
        do_reset();
        w0 = writes;
        d0 = dones;
        put(4'h3, 4'h0, 4'hF, 4'h3, 64'h0123456789ABCDEF);
        tick();
        tick();
        #5;
        reset = 1'b1;
        #1;
        check("t6_we_drop", {63'd0, mem_we}, 64'd0);
        check("t6_no_done", {63'd0, done},   64'd0);
        check("t6_val_p",   val_p,           64'd0);
        @(negedge clock);
        #2;
        reset = 1'b0;
        tick();
        check("t6_writes", 64'(writes - w0), 64'd3);
        check("t6_dones",  64'(dones - d0),  64'd0);
        check("t6_m2", {56'd0, mem[2]}, 64'hEF);
        put(4'h0, 4'h0, 4'h0, 4'h0, 64'd0);
        wait_done("t6_halt_lat", 1);
        tick();
        check("t6_m0", {56'd0, mem[0]}, 64'h00);
        check("t6_val_p_halt", val_p, 64'd1);
        check("t6_ready_after_halt", {63'd0, in_ready}, 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/y86_instr_encoder.md
Name: y86_instr_encoder

Overview:
Inverse of the SEQ fetch stage: takes decoded Y86-64 instruction fields over a valid/ready handshake and serialises them into byte-wide writes to the 1024-byte instruction memory.
Writes one byte per cycle, little-endian valC, with the same per-icode lengths the fetch stage decodes.
Used by the testbench/loader path to build programs in memory instead of relying on a pre-assembled text file.

Parameters:
MEM_SIZE, 1024, instruction memory size in bytes; the last valid address is MEM_SIZE-1
BASE_ADDR, 0, write-pointer value after reset

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  instruction fields are valid
in_ready  output  1  encoder can accept an instruction
in_code  input  4  icode
in_fun  input  4  ifun
ra  input  4  rA field
rb  input  4  rB field
val_c  input  64  constant or displacement
addr_load  input  1  load the write pointer (honoured only in IDLE)
addr_value  input  64  new write-pointer value
mem_we  output  1  byte write strobe
mem_addr  output  64  byte address
mem_wdata  output  8  byte data
val_p  output  64  current write pointer, i.e. the address of the next instruction
done  output  1  one-cycle pulse with the last byte of each instruction
in_error  output  1  sticky flag: invalid icode
bad_mem  output  1  sticky flag: instruction would cross MEM_SIZE

Behaviour:
- Reset (async): state=IDLE, val_p=BASE_ADDR. Outputs in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, done=0, in_error=0, bad_mem=0.
- Lengths:
  - 1 byte: icode 0, 1, 9.
  - 2 bytes: icode 2, 6, A, B.
  - 9 bytes: icode 7, 8.
  - 10 bytes: icode 3, 4, 5.
  - icode C-F is invalid.
- Byte image:
  - b0={in_code,in_fun}.
  - icode 2,3,4,5,6,A,B: b1={ra,rb}; for 3/4/5, b2..b9=val_c[7:0]..val_c[63:56].
  - icode 7,8: b1..b8=val_c[7:0]..val_c[63:56]; there is no register byte.
  - icode 0,1,9: b0 only. ra, rb and val_c are ignored when unused.
- FSM states: IDLE, EMIT, HALTED_ERR.
- IDLE:
  - in_ready=1 (registered).
  - If addr_load=1: val_p<=addr_value. No instruction is accepted that cycle, even if in_valid=1 (load has priority).
  - Otherwise, if in_valid=1: latch all fields, idx<=0, len<=L.
    - Invalid icode: in_error<=1, go to HALTED_ERR, no writes.
    - val_p+L-1 > MEM_SIZE-1: bad_mem<=1, go to HALTED_ERR, no writes.
    - Otherwise go to EMIT; in_ready<=0.
- EMIT:
  - Each cycle: mem_we=1, mem_addr=val_p+idx, mem_wdata=b[idx], idx increments.
  - When idx==len-1: done=1 in that cycle. On the next edge: val_p<=val_p+len, state=IDLE, in_ready=1, mem_we=0.
  - addr_load and in_valid are ignored in EMIT.
- Latency: accept at edge N. Bytes are written in cycles N+1..N+len. done is asserted in cycle N+len. The next accept can happen no earlier than edge N+len+1.
- Back-to-back: one idle cycle between instructions. Throughput is len+1 cycles per instruction.
- HALTED_ERR: in_ready=0 and mem_we=0 until reset. The error flags stay set; val_p is unchanged.
- Halt (icode 0) encodes normally and does not stop the encoder.
- Exact fit: an instruction whose last byte lands at MEM_SIZE-1 is legal. After it, val_p=MEM_SIZE, so any further accept raises bad_mem.
- Reset mid-EMIT: mem_we drops immediately, with no done pulse. val_p returns to BASE_ADDR. Bytes already written stay in memory.
- Address arithmetic is 64-bit unsigned. The bounds check is done in 65-bit to avoid wrap-around when val_p is near 2^64.

Decomposition:
- Shared package y86_isa_pkg holds:
  - icode constants: I_HALT=0, I_NOP=1, I_RRMOVQ=2, I_IRMOVQ=3, I_RMMOVQ=4, I_MRMOVQ=5, I_OPQ=6, I_JXX=7, I_CALL=8, I_RET=9, I_PUSHQ=A, I_POPQ=B.
  - RNONE=4'hF.
  - the state encoding.
  - instruction-length constants.
- One combinational sub-module, y86_instr_len: icode in -> 4-bit length plus a valid bit, and flags has_regs / has_valc. The fetch stage can reuse it.

Test Plan:
1. Reset, then irmovq: code=3, fun=0, ra=F, rb=3, val_c=64'h0123456789ABCDEF at val_p=0 -> bytes 30 F3 EF CD AB 89 67 45 23 01 at addresses 0..9. done is asserted in cycle 10 and val_p=10.
2. Back-to-back from addr 10: addq (6,0,ra=2,rb=3) then call 0x40 (8,0) then ret (9,0) -> 60 23 @10..11; 80 40 00 00 00 00 00 00 00 @12..20; 90 @21. Final val_p=22 and there are exactly three done pulses.
3. Invalid icode: code=C at val_p=5 -> in_error=1, mem_we is never asserted, in_ready=0 permanently. After reset, in_error=0 and val_p=0.
4. Boundary: addr_load=1010, then irmovq (len 10) -> bytes at 1010..1019 and val_p=1020. Next mrmovq (len 10) -> bad_mem=1 and no writes. Separately, addr_load=1023 then nop -> write at 1023 is legal, val_p=1024.
5. Simultaneous addr_load=100 with in_valid for a nop in IDLE -> pointer becomes 100, the nop is not accepted. Holding in_valid for the next cycle -> the nop writes 10 at address 100.
6. Assert reset during byte 4 of an irmovq -> mem_we goes to 0 immediately, no done pulse, val_p=BASE_ADDR. A following halt then writes 00 at address 0.
